// File: rtl/spiflash_arb_pkg.sv
// Shared types and constants for the two-port SPI flash word-read arbiter.
package spiflash_arb_pkg;

   typedef enum logic [1:0] {IDLE, SETUP, SHIFT, DONE} state_t;

   localparam logic [7:0] CMD_READ   = 8'h03;
   localparam int         FRAME_BITS = 64;
   localparam int         DATA_BITS  = 32;

   // Flash streams bytes MSB first, lowest byte address first; the shift register
   // therefore holds the first received byte in its top data byte.
   function automatic logic [DATA_BITS-1:0] byte_order(input logic [DATA_BITS-1:0] s);
      return {s[7:0], s[15:8], s[23:16], s[31:24]};
   endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// SCK phase timing: DIV-cycle phases, mode-0 clock level, per-bit sample tick and frame end.
module spi_sck_gen
   import spiflash_arb_pkg::*;
#(
   parameter int DIV = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       shift_en,
   output logic       sck,
   output logic       phase_end,
   output logic       sample_tick,
   output logic       frame_end,
   output logic [6:0] bit_cnt
);

   logic [7:0] phase_cnt;

   assign phase_end   = en && (phase_cnt == 8'(DIV - 1));
   // Last cycle of a high phase: miso is captured and mosi advances on this edge.
   assign sample_tick = phase_end && shift_en && sck;
   assign frame_end   = phase_end && shift_en && !sck && (bit_cnt == 7'(FRAME_BITS));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_cnt <= '0;
         sck       <= 1'b0;
         bit_cnt   <= '0;
      end else if (!en) begin
         phase_cnt <= '0;
         sck       <= 1'b0;
         bit_cnt   <= '0;
      end else begin
         phase_cnt <= phase_end ? 8'd0 : phase_cnt + 8'd1;
         if (phase_end) begin
            if (!shift_en) begin
               sck <= 1'b1;
            end else if (sck) begin
               sck     <= 1'b0;
               bit_cnt <= bit_cnt + 7'd1;
            end else begin
               // After the last bit the low phase doubles as CS hold time.
               sck <= (bit_cnt != 7'(FRAME_BITS));
            end
         end
      end
   end

endmodule

// File: rtl/spiflash_read_arbiter.sv
// Round-robin arbiter sharing one SPI flash between two word-read ports; each grant
// runs one READ (0x03) frame and returns the word with a one-cycle ack.
module spiflash_read_arbiter
   import spiflash_arb_pkg::*;
#(
   parameter int DIV    = 2,
   parameter int ADDR_W = 24
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   input  logic              req0_valid,
   input  logic [ADDR_W-1:0] req0_addr,
   output logic              req0_ack,
   output logic [31:0]       req0_rdata,
   input  logic              req1_valid,
   input  logic [ADDR_W-1:0] req1_addr,
   output logic              req1_ack,
   output logic [31:0]       req1_rdata,
   output logic              spiflash_cs_n,
   output logic              spiflash_clk,
   output logic              spiflash_mosi,
   input  logic              spiflash_miso,
   output logic              busy
);

   state_t                state;
   logic                  port;
   logic                  last_port;
   logic [FRAME_BITS-1:0] shift;
   logic                  grant1;
   logic                  sck_en;
   logic                  shift_en;
   logic                  phase_end;
   logic                  sample_tick;
   logic                  frame_end;
   logic [6:0]            bit_cnt;

   assign sck_en   = (state == SETUP) || (state == SHIFT);
   assign shift_en = (state == SHIFT);
   assign grant1   = req1_valid && (!req0_valid || !last_port);

   spi_sck_gen #(.DIV(DIV)) u_sck_gen (
      .clk         (sys_clk),
      .rst_n       (sys_rst_n),
      .en          (sck_en),
      .shift_en    (shift_en),
      .sck         (spiflash_clk),
      .phase_end   (phase_end),
      .sample_tick (sample_tick),
      .frame_end   (frame_end),
      .bit_cnt     (bit_cnt)
   );

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state         <= IDLE;
         port          <= 1'b0;
         last_port     <= 1'b1;  // pretend port 1 went last so port 0 wins the first tie
         shift         <= '0;
         spiflash_cs_n <= 1'b1;
         spiflash_mosi <= 1'b0;
         req0_ack      <= 1'b0;
         req1_ack      <= 1'b0;
         req0_rdata    <= '0;
         req1_rdata    <= '0;
         busy          <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req0_valid || req1_valid) begin
                  port          <= grant1;
                  shift         <= {CMD_READ, (grant1 ? req1_addr : req0_addr), {DATA_BITS{1'b0}}};
                  spiflash_mosi <= CMD_READ[7];
                  spiflash_cs_n <= 1'b0;
                  busy          <= 1'b1;
                  state         <= SETUP;
               end
            end
            SETUP: begin
               if (phase_end) state <= SHIFT;
            end
            SHIFT: begin
               if (sample_tick) begin
                  shift         <= {shift[FRAME_BITS-2:0], spiflash_miso};
                  spiflash_mosi <= (bit_cnt < 7'(DATA_BITS - 1)) ? shift[FRAME_BITS-2] : 1'b0;
               end
               if (frame_end) begin
                  spiflash_cs_n <= 1'b1;
                  if (port) begin
                     req1_ack   <= 1'b1;
                     req1_rdata <= byte_order(shift[DATA_BITS-1:0]);
                  end else begin
                     req0_ack   <= 1'b1;
                     req0_rdata <= byte_order(shift[DATA_BITS-1:0]);
                  end
                  state <= DONE;
               end
            end
            DONE: begin
               req0_ack  <= 1'b0;
               req1_ack  <= 1'b0;
               busy      <= 1'b0;
               last_port <= port;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spiflash_read_arbiter.sv
// Randomized self-checking bench: two arbiter builds (DIV=2 and DIV=1), each with a bit-level flash model.
module tb_spiflash_read_arbiter;

   localparam int LAT2 = 129 * 2 + 1;
   localparam int LAT1 = 129 * 1 + 1;

   logic        sys_clk = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic        req0_valid [2];
   logic        req1_valid [2];
   logic [23:0] req0_addr  [2];
   logic [23:0] req1_addr  [2];
   logic        req0_ack   [2];
   logic        req1_ack   [2];
   logic [31:0] req0_rdata [2];
   logic [31:0] req1_rdata [2];
   logic        cs_n [2];
   logic        sck  [2];
   logic        mosi [2];
   logic        busy [2];
   int          cyc = 0;
   int          tests_run = 0;
   int          failed = 0;
   int          model_last = 1;

   always #5 sys_clk = ~sys_clk;
   always @(posedge sys_clk) cyc <= cyc + 1;

   function automatic logic [7:0] flash_byte(input logic [23:0] a);
      logic [23:0] t;
      case (a)
         24'h000010: return 8'h11;
         24'h000011: return 8'h22;
         24'h000012: return 8'h33;
         24'h000013: return 8'h44;
         24'hFFFFFC: return 8'hAA;
         24'hFFFFFD: return 8'hBB;
         24'hFFFFFE: return 8'hCC;
         24'hFFFFFF: return 8'hDD;
         default: begin
            t = (a * 24'd37) ^ (a >> 5);
            return t[7:0] + 8'h5A;
         end
      endcase
   endfunction

   // First byte lands in bits [7:0], fourth byte in [31:24].
   function automatic logic [31:0] expect_word(input logic [23:0] a);
      return {flash_byte(a + 24'd3), flash_byte(a + 24'd2), flash_byte(a + 24'd1), flash_byte(a)};
   endfunction

   for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      logic        miso = 1'b0;
      logic [31:0] cmd = '0;
      logic [31:0] frame_cmd = '0;
      logic        prev_sck = 1'b0;
      logic        prev_cs = 1'b1;
      logic [7:0]  fbyte;
      int          rises = 0;
      int          frame_rises = 0;
      int          hi_run = 0;
      int          last_gap = 0;
      int          frames = 0;
      int          acks0 = 0;
      int          acks1 = 0;
      int          last_rise = 0;
      int          per_min = 999;
      int          per_max = 0;
      int          kbit;

      spiflash_read_arbiter #(.DIV(gi == 0 ? 2 : 1), .ADDR_W(24)) dut (
         .sys_clk       (sys_clk),
         .sys_rst_n     (sys_rst_n),
         .req0_valid    (req0_valid[gi]),
         .req0_addr     (req0_addr[gi]),
         .req0_ack      (req0_ack[gi]),
         .req0_rdata    (req0_rdata[gi]),
         .req1_valid    (req1_valid[gi]),
         .req1_addr     (req1_addr[gi]),
         .req1_ack      (req1_ack[gi]),
         .req1_rdata    (req1_rdata[gi]),
         .spiflash_cs_n (cs_n[gi]),
         .spiflash_clk  (sck[gi]),
         .spiflash_mosi (mosi[gi]),
         .spiflash_miso (miso),
         .busy          (busy[gi])
      );

      // Mode-0 flash: captures mosi on SCK rise, presents the next data bit after SCK fall.
      initial forever begin
         @(negedge sys_clk);
         if (req0_ack[gi] === 1'b1) acks0++;
         if (req1_ack[gi] === 1'b1) acks1++;
         if (cs_n[gi] !== 1'b0) begin
            if (!prev_cs) begin
               frame_cmd   = cmd;
               frame_rises = rises;
            end
            hi_run++;
            rises = 0;
         end else begin
            if (prev_cs) begin
               last_gap = hi_run;
               hi_run   = 0;
               frames++;
               per_min  = 999;
               per_max  = 0;
               cmd      = '0;
            end
            if (sck[gi] === 1'b1 && !prev_sck) begin
               if (rises < 32) cmd = {cmd[30:0], mosi[gi]};
               if (rises > 0) begin
                  if (cyc - last_rise < per_min) per_min = cyc - last_rise;
                  if (cyc - last_rise > per_max) per_max = cyc - last_rise;
               end
               last_rise = cyc;
               rises++;
            end else if (sck[gi] === 1'b0 && prev_sck && rises >= 32 && rises < 64) begin
               kbit  = rises - 32;
               fbyte = flash_byte(cmd[23:0] + 24'(kbit / 8));
               miso  = fbyte[7 - (kbit % 8)];
            end
         end
         prev_cs  = (cs_n[gi] !== 1'b0);
         prev_sck = (sck[gi] === 1'b1);
      end
   end

   task automatic wait_ack(input int inst, input int port, input int budget, output int lat);
      lat = -1;
      for (int k = 1; k <= budget; k++) begin
         @(negedge sys_clk);
         if ((port == 0 && req0_ack[inst] === 1'b1) || (port == 1 && req1_ack[inst] === 1'b1)) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic test_reset;
      @(negedge sys_clk);
      @(negedge sys_clk);
      for (int i = 0; i < 2; i++) begin
         tests_run++;
         if ({cs_n[i], sck[i], mosi[i], req0_ack[i], req1_ack[i], busy[i]} !== 6'b100000) begin
            failed++;
            $display("FAIL reset_ctrl[%0d]: got %b expected 100000", i,
                     {cs_n[i], sck[i], mosi[i], req0_ack[i], req1_ack[i], busy[i]});
         end
         tests_run++;
         if ({req0_rdata[i], req1_rdata[i]} !== 64'h0) begin
            failed++;
            $display("FAIL reset_rdata[%0d]: got %h expected 0", i, {req0_rdata[i], req1_rdata[i]});
         end
      end
      sys_rst_n = 1'b1;
      repeat (3) @(negedge sys_clk);
      tests_run++;
      if (cs_n[0] !== 1'b1 || busy[0] !== 1'b0) begin
         failed++;
         $display("FAIL idle_after_reset: got cs_n=%b busy=%b expected cs_n=1 busy=0", cs_n[0], busy[0]);
      end
   endtask

   task automatic test_single_read;
      int a1_before;
      int lat;
      logic busy_mid;
      a1_before = g_dut[0].acks1;
      req0_addr[0]  = 24'h000010;
      req0_valid[0] = 1'b1;
      repeat (10) @(negedge sys_clk);
      busy_mid = busy[0];
      wait_ack(0, 0, 600, lat);
      if (lat > 0) lat = lat + 10;
      req0_valid[0] = 1'b0;
      model_last = 0;
      $display("[TB] single port0 addr 000010 rdata %h lat %0d", req0_rdata[0], lat);
      tests_run++;
      if (lat != LAT2) begin
         failed++;
         $display("FAIL single_latency: got %0d expected %0d", lat, LAT2);
      end
      tests_run++;
      if (req0_rdata[0] !== 32'h44332211) begin
         failed++;
         $display("FAIL single_rdata: got %h expected 44332211", req0_rdata[0]);
      end
      tests_run++;
      if (busy_mid !== 1'b1) begin
         failed++;
         $display("FAIL single_busy: got %b expected 1", busy_mid);
      end
      @(negedge sys_clk);
      tests_run++;
      if (req0_ack[0] !== 1'b0 || busy[0] !== 1'b0) begin
         failed++;
         $display("FAIL single_ack_width: got ack=%b busy=%b expected 0 0", req0_ack[0], busy[0]);
      end
      @(negedge sys_clk);
      tests_run++;
      if (g_dut[0].frame_cmd !== 32'h03000010) begin
         failed++;
         $display("FAIL single_mosi_frame: got %h expected 03000010", g_dut[0].frame_cmd);
      end
      tests_run++;
      if (g_dut[0].frame_rises != 64 || g_dut[0].per_min != 4 || g_dut[0].per_max != 4) begin
         failed++;
         $display("FAIL single_sck: got rises=%0d period %0d..%0d expected 64 4..4",
                  g_dut[0].frame_rises, g_dut[0].per_min, g_dut[0].per_max);
      end
      tests_run++;
      if (g_dut[0].acks1 != a1_before) begin
         failed++;
         $display("FAIL single_no_ack1: got %0d acks expected 0", g_dut[0].acks1 - a1_before);
      end
   endtask

   task automatic test_simultaneous;
      int frames_before;
      int a1_before;
      int lat;
      sys_rst_n = 1'b0;
      repeat (2) @(negedge sys_clk);
      sys_rst_n = 1'b1;
      model_last = 1;
      @(negedge sys_clk);
      frames_before = g_dut[0].frames;
      a1_before     = g_dut[0].acks1;
      req0_addr[0]  = 24'h000010;
      req1_addr[0]  = 24'h000020;
      req0_valid[0] = 1'b1;
      req1_valid[0] = 1'b1;
      wait_ack(0, 0, 600, lat);
      req0_valid[0] = 1'b0;
      $display("[TB] tie port0 addr 000010 rdata %h lat %0d", req0_rdata[0], lat);
      tests_run++;
      if (lat != LAT2 || g_dut[0].acks1 != a1_before) begin
         failed++;
         $display("FAIL tie_port0_first: got lat=%0d acks1=%0d expected lat=%0d acks1=0",
                  lat, g_dut[0].acks1 - a1_before, LAT2);
      end
      tests_run++;
      if (req0_rdata[0] !== expect_word(24'h000010)) begin
         failed++;
         $display("FAIL tie_rdata0: got %h expected %h", req0_rdata[0], expect_word(24'h000010));
      end
      wait_ack(0, 1, 600, lat);
      req1_valid[0] = 1'b0;
      model_last = 1;
      $display("[TB] tie port1 addr 000020 rdata %h gap %0d", req1_rdata[0], lat);
      tests_run++;
      if (lat != LAT2 + 1) begin
         failed++;
         $display("FAIL tie_ack_spacing: got %0d expected %0d", lat, LAT2 + 1);
      end
      tests_run++;
      if (req1_rdata[0] !== expect_word(24'h000020)) begin
         failed++;
         $display("FAIL tie_rdata1: got %h expected %h", req1_rdata[0], expect_word(24'h000020));
      end
      repeat (2) @(negedge sys_clk);
      tests_run++;
      if (g_dut[0].frames != frames_before + 2 || g_dut[0].last_gap < 2) begin
         failed++;
         $display("FAIL tie_frames: got frames=%0d gap=%0d expected 2 frames gap>=2",
                  g_dut[0].frames - frames_before, g_dut[0].last_gap);
      end
   endtask

   task automatic test_round_robin;
      int exp_port;
      int got;
      logic [31:0] got_data;
      logic [23:0] exp_addr;
      req0_addr[0]  = 24'($urandom);
      req1_addr[0]  = 24'($urandom);
      req0_valid[0] = 1'b1;
      req1_valid[0] = 1'b1;
      for (int t = 0; t < 4; t++) begin
         exp_port = (model_last == 1) ? 0 : 1;
         exp_addr = (exp_port == 0) ? req0_addr[0] : req1_addr[0];
         got      = -1;
         got_data = '0;
         for (int k = 1; k <= 600; k++) begin
            @(negedge sys_clk);
            if (req0_ack[0] === 1'b1) begin
               got = 0;
               got_data = req0_rdata[0];
               break;
            end
            if (req1_ack[0] === 1'b1) begin
               got = 1;
               got_data = req1_rdata[0];
               break;
            end
         end
         $display("[TB] rr txn %0d port %0d addr %h rdata %h", t, got, exp_addr, got_data);
         tests_run++;
         if (got != exp_port) begin
            failed++;
            $display("FAIL rr_order[%0d]: got port %0d expected port %0d", t, got, exp_port);
         end
         tests_run++;
         if (got_data !== expect_word(exp_addr)) begin
            failed++;
            $display("FAIL rr_rdata[%0d]: got %h expected %h", t, got_data, expect_word(exp_addr));
         end
         model_last = exp_port;
         if (exp_port == 0) req0_addr[0] = 24'($urandom);
         else               req1_addr[0] = 24'($urandom);
      end
      req0_valid[0] = 1'b0;
      req1_valid[0] = 1'b0;
      repeat (3) @(negedge sys_clk);
      tests_run++;
      if (busy[0] !== 1'b0) begin
         failed++;
         $display("FAIL rr_idle: got busy=%b expected 0", busy[0]);
      end
   endtask

   task automatic test_random;
      int p;
      int lat;
      int other_acks;
      logic [23:0] addr;
      logic [31:0] other_rdata;
      logic [31:0] got_data;
      for (int t = 0; t < 6; t++) begin
         p           = int'($urandom_range(1, 0));
         addr        = 24'($urandom);
         other_rdata = (p == 1) ? req0_rdata[0] : req1_rdata[0];
         other_acks  = (p == 1) ? g_dut[0].acks0 : g_dut[0].acks1;
         if (p == 0) begin
            req0_addr[0] = addr;
            req0_valid[0] = 1'b1;
         end else begin
            req1_addr[0] = addr;
            req1_valid[0] = 1'b1;
         end
         lat = -1;
         for (int k = 1; k <= 600; k++) begin
            @(negedge sys_clk);
            if (k == 40 && t == 2) begin
               req0_addr[0] = ~addr;
               req1_addr[0] = ~addr;
            end
            if (k == 40 && t == 4) begin
               req0_valid[0] = 1'b0;
               req1_valid[0] = 1'b0;
            end
            if ((p == 0 && req0_ack[0] === 1'b1) || (p == 1 && req1_ack[0] === 1'b1)) begin
               lat = k;
               break;
            end
         end
         req0_valid[0] = 1'b0;
         req1_valid[0] = 1'b0;
         got_data = (p == 0) ? req0_rdata[0] : req1_rdata[0];
         model_last = p;
         $display("[TB] random txn %0d port %0d addr %h rdata %h lat %0d", t, p, addr, got_data, lat);
         tests_run++;
         if (lat != LAT2 || got_data !== expect_word(addr)) begin
            failed++;
            $display("FAIL random_read[%0d]: got lat=%0d rdata=%h expected lat=%0d rdata=%h",
                     t, lat, got_data, LAT2, expect_word(addr));
         end
         tests_run++;
         if (((p == 1) ? req0_rdata[0] : req1_rdata[0]) !== other_rdata ||
             ((p == 1) ? g_dut[0].acks0 : g_dut[0].acks1) != other_acks) begin
            failed++;
            $display("FAIL random_other_port[%0d]: got rdata=%h expected rdata=%h with no ack", t,
                     (p == 1) ? req0_rdata[0] : req1_rdata[0], other_rdata);
         end
         @(negedge sys_clk);
      end
   endtask

   task automatic test_reset_mid_frame;
      int lat;
      int acks_before;
      logic reached;
      req0_addr[0]  = 24'($urandom);
      req0_valid[0] = 1'b1;
      reached = 1'b0;
      for (int k = 1; k <= 400; k++) begin
         @(negedge sys_clk);
         if (g_dut[0].rises == 21) begin
            reached = 1'b1;
            break;
         end
      end
      tests_run++;
      if (!reached) begin
         failed++;
         $display("FAIL reset_mid_reach_bit20: got rises=%0d expected 21", g_dut[0].rises);
      end
      acks_before = g_dut[0].acks0 + g_dut[0].acks1;
      #2;
      sys_rst_n = 1'b0;
      #1;
      tests_run++;
      if ({cs_n[0], sck[0], busy[0], req0_ack[0]} !== 4'b1000) begin
         failed++;
         $display("FAIL reset_mid_async: got cs_n,sck,busy,ack=%b expected 1000",
                  {cs_n[0], sck[0], busy[0], req0_ack[0]});
      end
      req0_valid[0] = 1'b0;
      repeat (3) @(negedge sys_clk);
      sys_rst_n = 1'b1;
      model_last = 1;
      repeat (2) @(negedge sys_clk);
      tests_run++;
      if (g_dut[0].acks0 + g_dut[0].acks1 != acks_before) begin
         failed++;
         $display("FAIL reset_mid_no_ack: got %0d acks expected 0",
                  g_dut[0].acks0 + g_dut[0].acks1 - acks_before);
      end
      req1_addr[0]  = 24'h000004;
      req1_valid[0] = 1'b1;
      wait_ack(0, 1, 600, lat);
      req1_valid[0] = 1'b0;
      model_last = 1;
      $display("[TB] post-reset port1 addr 000004 rdata %h lat %0d", req1_rdata[0], lat);
      tests_run++;
      if (lat != LAT2 || req1_rdata[0] !== expect_word(24'h000004)) begin
         failed++;
         $display("FAIL reset_mid_recover: got lat=%0d rdata=%h expected lat=%0d rdata=%h",
                  lat, req1_rdata[0], LAT2, expect_word(24'h000004));
      end
      repeat (2) @(negedge sys_clk);
      tests_run++;
      if (g_dut[0].frame_rises != 64 || g_dut[0].frame_cmd !== 32'h03000004) begin
         failed++;
         $display("FAIL reset_mid_frame: got rises=%0d cmd=%h expected 64 03000004",
                  g_dut[0].frame_rises, g_dut[0].frame_cmd);
      end
   endtask

   task automatic test_div1;
      int lat;
      logic [23:0] addr;
      addr = 24'($urandom);
      req0_addr[1]  = addr;
      req0_valid[1] = 1'b1;
      wait_ack(1, 0, 300, lat);
      req0_valid[1] = 1'b0;
      $display("[TB] div1 port0 addr %h rdata %h lat %0d", addr, req0_rdata[1], lat);
      tests_run++;
      if (lat != LAT1) begin
         failed++;
         $display("FAIL div1_latency: got %0d expected %0d", lat, LAT1);
      end
      tests_run++;
      if (req0_rdata[1] !== expect_word(addr)) begin
         failed++;
         $display("FAIL div1_rdata: got %h expected %h", req0_rdata[1], expect_word(addr));
      end
      repeat (2) @(negedge sys_clk);
      tests_run++;
      if (g_dut[1].frame_rises != 64 || g_dut[1].per_min != 2 || g_dut[1].per_max != 2) begin
         failed++;
         $display("FAIL div1_sck: got rises=%0d period %0d..%0d expected 64 2..2",
                  g_dut[1].frame_rises, g_dut[1].per_min, g_dut[1].per_max);
      end
   endtask

   task automatic test_top_address;
      int lat;
      req1_addr[0]  = 24'hFFFFFC;
      req1_valid[0] = 1'b1;
      wait_ack(0, 1, 600, lat);
      req1_valid[0] = 1'b0;
      model_last = 1;
      $display("[TB] top port1 addr fffffc rdata %h lat %0d", req1_rdata[0], lat);
      tests_run++;
      if (lat != LAT2 || req1_rdata[0] !== 32'hDDCCBBAA) begin
         failed++;
         $display("FAIL top_addr_read: got lat=%0d rdata=%h expected lat=%0d rdata=ddccbbaa",
                  lat, req1_rdata[0], LAT2);
      end
      repeat (2) @(negedge sys_clk);
      tests_run++;
      if (g_dut[0].frame_cmd !== 32'h03FFFFFC) begin
         failed++;
         $display("FAIL top_addr_mosi: got %h expected 03fffffc", g_dut[0].frame_cmd);
      end
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         req0_valid[i] = 1'b0;
         req1_valid[i] = 1'b0;
         req0_addr[i]  = '0;
         req1_addr[i]  = '0;
      end
      test_reset;
      test_single_read;
      test_simultaneous;
      test_round_robin;
      test_random;
      test_reset_mid_frame;
      test_div1;
      test_top_address;
      $display("[TB] %0d tests run, %0d failed", tests_run, failed);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, %0d tests run", tests_run);
      $fatal(1, "watchdog expired");
   end

endmodule
